sys_ctrl: RTL and testbench
===========================

SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- BASE, 32'h600d6000, register window base address (4 words, 16 bytes).
- LED_W, 4, LED register width (1..32).
- DIV_LOG2, 3, clock-enable divide ratio is 2^DIV_LOG2 (0..8).
- RST_HOLD, 16, number of cycles core reset is held after reset release (1..255).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, the single clock; everything is on its rising edge.
- reset_n, in, 1, synchronous, active-low reset.
- addr, in, 32, byte address of the data-port access.
- data_i, in, 32, write data.
- data_en, in, 1, read strobe.
- write_en, in, 1, write strobe.
- data_o, out, 32, registered read data.
- ready, out, 1, access-complete pulse.
- clk_en, out, 1, divided clock-enable pulse.
- core_reset, out, 1, active-high reset to the core.
- led, out, LED_W, LED register.
- done, out, 1, sticky exit flag.
- exit_code, out, 32, last value written to EXIT.

Function
REQ-003 Select is addr[31:4]==BASE[31:4]; word offset is addr[3:2]; addr[1:0] is ignored.
REQ-004 Register map: 0x0 LED (read/write, low LED_W bits, upper bits read 0); 0x4 CYC_LO (read-only); 0x8 CYC_HI (read-only, returns the shadow); 0xC EXIT (write; reads return exit_code).
REQ-005 Read latency is exactly 1 cycle: a selected data_en or write_en in cycle N gives ready=1 in cycle N+1 for exactly one cycle, with data_o valid on reads.
REQ-006 An unselected access gives ready=0, changes no state and leaves data_o unchanged.
REQ-007 data_en and write_en asserted together are treated as a write; data_o then returns the pre-write register value.
REQ-008 Reset FSM states HOLD, RUN, HALT:
- HOLD: core_reset=1; counts RST_HOLD cycles, then goes to RUN.
- RUN: core_reset=0; a selected write to EXIT goes to HALT.
- HALT: core_reset=1; terminal until reset_n=0.
REQ-009 In HOLD and HALT, writes are acknowledged (ready pulses) but ignored; reads operate normally.
REQ-010 EXIT write in RUN: exit_code<=data_i and done<=1 in the same edge; done remains set until reset.
REQ-011 Cycle counter: 64 bits, increments by 1 every cycle in RUN only, frozen in HOLD/HALT, wraps 2^64-1 -> 0 silently.
REQ-012 A read of CYC_LO returns the counter value before that cycle's increment and copies bits [63:32] of that same value into a 32-bit shadow; CYC_HI returns the shadow, giving coherent 64-bit reads.
REQ-013 clk_en: a DIV_LOG2-bit free-running counter from reset; clk_en=1 in the cycle the counter is all-ones, i.e. one cycle in every 2^DIV_LOG2; with DIV_LOG2=0, clk_en=1 constantly.
REQ-014 An LED write updates led on the edge ending the write cycle.

Reset
REQ-015 reset_n=0 at any edge, including mid-access or in HALT, produces: FSM=HOLD, hold count=0, core_reset=1, counter=0, shadow=0, led=0, done=0, exit_code=0, data_o=0, ready=0, divider=0, clk_en=0 (1 if DIV_LOG2=0).
REQ-016 An access pending when reset asserts is dropped; no ready pulse follows.

Structure
REQ-017 A shared package psp_pkg holds the FSM state enum and the register offset constants (LED, CYC_LO, CYC_HI, EXIT).
REQ-018 The divider is one sub-module, clk_en_gen, parametrised by DIV_LOG2; all other logic is flat in sys_ctrl.

Verification
REQ-019 Release reset with RST_HOLD=16 -> core_reset=1 for exactly 16 cycles, then 0; CYC_LO read at 3 cycles after RUN returns 2.
REQ-020 Write 0xA to 0x600d6000, then read it -> led=4'hA one cycle after the write; read data_o=0xA and ready pulses once.
REQ-021 Preload counter to 0x0000_0000_FFFF_FFFF, read CYC_LO then CYC_HI -> 0xFFFFFFFF then 0x00000000, even though the counter has since carried.
REQ-022 Write 0x2A to 0x600d600c in RUN -> done=1, exit_code=0x2A, core_reset=1 next cycle, counter frozen; a later LED write is ignored.
REQ-023 Access 0x600d7000 -> ready stays 0 and no state changes; assert reset_n=0 in HALT -> all outputs at REQ-015 values on the next edge.
REQ-024 DIV_LOG2=3 -> clk_en high on cycles 7, 15, 23 after reset; DIV_LOG2=0 -> clk_en constant 1.

Source files
------------

// File: rtl/psp_pkg.sv
// Shared definitions for the sys_ctrl register block.
// Holds the reset-sequencer state encoding and the word offsets of the
// four registers in the 16-byte window (offset = addr[3:2]).
package psp_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } sys_state_e;

    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_CYC_LO = 2'd1;
    localparam logic [1:0] OFF_CYC_HI = 2'd2;
    localparam logic [1:0] OFF_EXIT   = 2'd3;

endpackage

// File: rtl/clk_en_gen.sv
// Free-running clock-enable generator.
// Ports:
//   clk     - system clock (rising edge)
//   reset_n - synchronous active-low reset
//   clk_en  - one-cycle pulse every 2^DIV_LOG2 cycles; constant 1 when DIV_LOG2 = 0
// The pulse is asserted while the counter is all-ones, so the first pulse
// appears 2^DIV_LOG2 - 1 cycles after reset release.
module clk_en_gen #(
    parameter int DIV_LOG2 = 3
) (
    input  logic clk,
    input  logic reset_n,
    output logic clk_en
);

    generate
        if (DIV_LOG2 == 0) begin : g_bypass
            logic unused_in;
            assign unused_in = clk ^ reset_n;
            assign clk_en    = 1'b1;
        end else begin : g_div
            logic [DIV_LOG2-1:0] cnt;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign clk_en = &cnt;
        end
    endgenerate

endmodule

// File: rtl/sys_ctrl.sv
// System control block: LED register, 64-bit run-cycle counter with a
// coherent high-word shadow, exit-code register and core reset sequencer.
// Ports:
//   clk, reset_n       - clock and synchronous active-low reset
//   addr, data_i       - byte address and write data of the data port
//   data_en, write_en  - read / write strobes
//   data_o, ready      - registered read data and one-cycle completion pulse
//   clk_en             - divided clock-enable pulse
//   core_reset         - active-high reset to the core (high in HOLD and HALT)
//   led                - LED register
//   done, exit_code    - sticky exit flag and last EXIT value
// Handshake: a selected access (data_en or write_en while addr hits the
// window) in cycle N is always completed with ready=1 in cycle N+1 for one
// cycle; there is no back-pressure. Both strobes together count as a write,
// and data_o then carries the register value from before the write.
module sys_ctrl
    import psp_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h600d6000,
    parameter int          LED_W    = 4,
    parameter int          DIV_LOG2 = 3,
    parameter int          RST_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      data_i,
    input  logic             data_en,
    input  logic             write_en,
    output logic [31:0]      data_o,
    output logic             ready,
    output logic             clk_en,
    output logic             core_reset,
    output logic [LED_W-1:0] led,
    output logic             done,
    output logic [31:0]      exit_code
);

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

    sys_state_e  state, state_nxt;
    logic [7:0]  hold_cnt;
    logic [63:0] cyc_cnt;
    logic [31:0] cyc_hi_shadow;
    logic [31:0] rdata;
    logic [1:0]  off;
    logic        sel, acc, wr, run_wr, exit_wr, lo_rd;
    logic        unused_addr;

    assign unused_addr = ^addr[1:0];

    assign sel     = (addr[31:4] == BASE[31:4]);
    assign off     = addr[3:2];
    assign acc     = sel && (data_en || write_en);
    assign wr      = sel && write_en;
    // Writes only take effect while the core is running.
    assign run_wr  = wr && (state == ST_RUN);
    assign exit_wr = run_wr && (off == OFF_EXIT);
    assign lo_rd   = sel && data_en && (off == OFF_CYC_LO);

    clk_en_gen #(.DIV_LOG2(DIV_LOG2)) u_clk_en_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en)
    );

    // Read mux over current (pre-write) register contents.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_LED:    rdata = 32'(led);
            OFF_CYC_LO: rdata = cyc_cnt[31:0];
            OFF_CYC_HI: rdata = cyc_hi_shadow;
            OFF_EXIT:   rdata = exit_code;
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        core_reset = 1'b1;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                core_reset = 1'b0;
                if (exit_wr) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_HOLD;
            hold_cnt      <= '0;
            cyc_cnt       <= '0;
            cyc_hi_shadow <= '0;
            led           <= '0;
            done          <= 1'b0;
            exit_code     <= '0;
            data_o        <= '0;
            ready         <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= acc;
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
            if (state == ST_RUN) begin
                cyc_cnt <= cyc_cnt + 64'd1;
            end
            if (acc) begin
                data_o <= rdata;
            end
            // Capture the high word of the same counter value the low-word
            // read returns, so a following CYC_HI read is coherent.
            if (lo_rd) begin
                cyc_hi_shadow <= cyc_cnt[63:32];
            end
            if (run_wr && (off == OFF_LED)) begin
                led <= data_i[LED_W-1:0];
            end
            if (exit_wr) begin
                exit_code <= data_i;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: reset sequencing, clock enable, register
// reads/writes, coherent counter reads, exit/halt behaviour and reset in HALT.
module tb_sys_ctrl;

    localparam logic [31:0] BASE = 32'h600d6000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic        data_en;
    logic        write_en;
    logic [31:0] data_o;
    logic        ready;
    logic        clk_en;
    logic        core_reset;
    logic [3:0]  led;
    logic        done;
    logic [31:0] exit_code;

    logic [31:0] d0_data_o;
    logic        d0_ready;
    logic        d0_clk_en;
    logic        d0_core_reset;
    logic [3:0]  d0_led;
    logic        d0_done;
    logic [31:0] d0_exit_code;

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    sys_ctrl #(.BASE(BASE), .LED_W(4), .DIV_LOG2(3), .RST_HOLD(16)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .data_i(data_i),
        .data_en(data_en), .write_en(write_en), .data_o(data_o), .ready(ready),
        .clk_en(clk_en), .core_reset(core_reset), .led(led), .done(done),
        .exit_code(exit_code)
    );

    sys_ctrl #(.BASE(BASE), .LED_W(4), .DIV_LOG2(0), .RST_HOLD(16)) dut_div0 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .data_i(data_i),
        .data_en(data_en), .write_en(write_en), .data_o(d0_data_o), .ready(d0_ready),
        .clk_en(d0_clk_en), .core_reset(d0_core_reset), .led(d0_led), .done(d0_done),
        .exit_code(d0_exit_code)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_en  = 1'b0;
        write_en = 1'b0;
        addr     = '0;
        data_i   = '0;
    endtask

    task automatic drive_rd(input logic [31:0] a);
        addr     = a;
        data_i   = '0;
        data_en  = 1'b1;
        write_en = 1'b0;
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [31:0] d);
        addr     = a;
        data_i   = d;
        data_en  = 1'b0;
        write_en = 1'b1;
    endtask

    // scoreboard comparison
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        tick();
        tick();

        // reset state
        check("rst_core_reset", core_reset, 1);
        check("rst_ready", ready, 0);
        check("rst_data_o", data_o, 0);
        check("rst_led", led, 0);
        check("rst_done", done, 0);
        check("rst_exit_code", exit_code, 0);
        check("rst_clk_en", clk_en, 0);
        check("rst_clk_en_div0", d0_clk_en, 1);

        // release: cycle k counts from the first cycle with reset_n high
        reset_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            check($sformatf("core_reset_c%0d", k), core_reset, (k < 16) ? 1 : 0);
            check($sformatf("clk_en_c%0d", k), clk_en, (k % 8 == 7) ? 1 : 0);
            check($sformatf("clk_en_div0_c%0d", k), d0_clk_en, 1);
            if (k == 18) drive_rd(BASE + 32'h4);
            if (k == 19) begin
                check("cyc_lo_third_run_ready", ready, 1);
                check("cyc_lo_third_run_data", data_o, 32'd2);
                idle();
            end
            if (k == 20) check("cyc_lo_ready_single", ready, 0);
            tick();
        end

        // LED write then read
        drive_wr(BASE, 32'hA);
        tick();
        check("led_after_write", led, 4'hA);
        check("led_write_ready", ready, 1);
        drive_rd(BASE);
        tick();
        check("led_read_ready", ready, 1);
        check("led_read_data", data_o, 32'hA);
        idle();
        tick();
        check("led_read_ready_drop", ready, 0);

        // upper bits beyond LED_W are dropped
        drive_wr(BASE + 32'h1, 32'h1F5);
        tick();
        check("led_masked", led, 4'h5);
        // both strobes: write wins, data_o shows the old value
        addr     = BASE;
        data_i   = 32'h3;
        data_en  = 1'b1;
        write_en = 1'b1;
        tick();
        check("rw_old_data", data_o, 32'h5);
        check("rw_led_new", led, 4'h3);
        check("rw_ready", ready, 1);
        idle();

        // coherent 64-bit read across a carry
        force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cyc_cnt;
        drive_rd(BASE + 32'h4);
        tick();
        check("carry_cyc_lo", data_o, 32'hFFFF_FFFF);
        drive_rd(BASE + 32'h8);
        tick();
        check("carry_cyc_hi_shadow", data_o, 32'h0);
        drive_rd(BASE + 32'h4);
        tick();
        check("post_carry_cyc_lo", data_o, 32'h1);
        drive_rd(BASE + 32'h8);
        tick();
        check("post_carry_cyc_hi", data_o, 32'h1);
        check("back_to_back_ready", ready, 1);

        // unselected access
        drive_wr(32'h600d7000, 32'hF);
        tick();
        check("unsel_ready", ready, 0);
        check("unsel_led", led, 4'h3);
        check("unsel_data_o", data_o, 32'h1);
        drive_rd(32'h600d7004);
        tick();
        check("unsel_rd_ready", ready, 0);
        check("unsel_rd_data_o", data_o, 32'h1);

        // EXIT write in RUN (counter is 0x1_0000_0005 here, becomes ..06)
        drive_wr(BASE + 32'hC, 32'h2A);
        tick();
        check("exit_done", done, 1);
        check("exit_code", exit_code, 32'h2A);
        check("exit_core_reset", core_reset, 1);
        check("exit_ready", ready, 1);
        drive_rd(BASE + 32'h4);
        tick();
        check("halt_cyc_lo_a", data_o, 32'h6);
        idle();
        tick();
        tick();
        tick();
        drive_rd(BASE + 32'h4);
        tick();
        check("halt_cyc_lo_frozen", data_o, 32'h6);
        drive_rd(BASE + 32'h8);
        tick();
        check("halt_cyc_hi", data_o, 32'h1);
        drive_wr(BASE, 32'h6);
        tick();
        check("halt_led_wr_ready", ready, 1);
        check("halt_led_ignored", led, 4'h3);
        drive_wr(BASE + 32'hC, 32'h55);
        tick();
        check("halt_exit_ignored", exit_code, 32'h2A);
        check("halt_done_sticky", done, 1);
        drive_rd(BASE + 32'hC);
        tick();
        check("halt_exit_read", data_o, 32'h2A);
        check("halt_core_reset", core_reset, 1);

        // reset in HALT with an access pending
        drive_rd(BASE);
        reset_n = 1'b0;
        tick();
        check("halt_rst_core_reset", core_reset, 1);
        check("halt_rst_ready", ready, 0);
        check("halt_rst_data_o", data_o, 0);
        check("halt_rst_led", led, 0);
        check("halt_rst_done", done, 0);
        check("halt_rst_exit_code", exit_code, 0);
        check("halt_rst_clk_en", clk_en, 0);
        check("halt_rst_clk_en_div0", d0_clk_en, 1);
        tick();
        check("rst_held_ready", ready, 0);
        reset_n = 1'b1;
        idle();
        tick();
        check("dropped_access_ready", ready, 0);
        check("rehold_core_reset", core_reset, 1);
        drive_rd(BASE + 32'h4);
        tick();
        check("rehold_cyc_lo", data_o, 32'h0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
